// File: rtl/fifo_wr_ptr_full_pkg.sv
// Shared definitions for the async FIFO pointer blocks (write-full and read-empty sides).
package fifo_wr_ptr_full_pkg;

  // Default RAM address width; depth is 2**DEF_ADDR_WIDTH.
  localparam int DEF_ADDR_WIDTH = 8;

  // Pointer width: one extra MSB distinguishes full from empty on a lap.
  function automatic int ptr_w(input int addr_width);
    return addr_width + 1;
  endfunction

  // Binary to Gray; callers slice the result down to their pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decode: each binary bit is the XOR of all Gray bits at or above it.
module gray_to_bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/fifo_wr_ptr_full.sv
// Write-domain pointer, RAM write port control and full / almost-full / occupancy flags.
module fifo_wr_ptr_full
  import fifo_wr_ptr_full_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_THRESH  = 2**ADDR_WIDTH - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rd_ptr_sync,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  overflow
);

  localparam int PW = ptr_w(ADDR_WIDTH);
  localparam logic [31:0] AF_T = 32'(AF_THRESH);

  logic [PW-1:0] wbin, wbin_next, gray_next, rbin, cnt_next, full_cmp;
  logic          push, full_next, af_next;

  // Read pointer decoded to binary for the occupancy subtraction.
  gray_to_bin #(.W(PW)) u_rd_g2b (
    .gray (rd_ptr_sync),
    .bin  (rbin)
  );

  // Gating with rst keeps the RAM write port idle while reset is held.
  assign push     = wr_en & ~full & rst;
  assign mem_we   = push;
  assign wr_addr  = wbin[ADDR_WIDTH-1:0];

  // Next pointer, Gray image and flags; the stale read pointer only overstates occupancy.
  always_comb begin
    wbin_next = wbin + PW'(push);
    gray_next = PW'(bin2gray(32'(wbin_next)));
    full_cmp  = {~rd_ptr_sync[ADDR_WIDTH:ADDR_WIDTH-1], rd_ptr_sync[ADDR_WIDTH-2:0]};
    full_next = (gray_next == full_cmp);
    cnt_next  = wbin_next - rbin;
    af_next   = (32'(cnt_next) >= AF_T);
  end

  // All write-side state registered; overflow is sticky until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbin        <= '0;
      wr_ptr_gray <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_count    <= '0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wr_ptr_gray <= gray_next;
      full        <= full_next;
      almost_full <= af_next;
      wr_count    <= cnt_next;
      if (wr_en && full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_ptr_full.sv
// Directed bench for fifo_wr_ptr_full at depth 8, almost-full threshold 6.
module tb_fifo_wr_ptr_full;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [3:0] rd_ptr_sync;
  logic       mem_we;
  logic [2:0] wr_addr;
  logic [3:0] wr_ptr_gray;
  logic       full;
  logic       almost_full;
  logic [3:0] wr_count;
  logic       overflow;

  int n_chk = 0;
  int n_err = 0;

  fifo_wr_ptr_full #(.ADDR_WIDTH(3), .AF_THRESH(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_ptr_sync (rd_ptr_sync),
    .mem_we      (mem_we),
    .wr_addr     (wr_addr),
    .wr_ptr_gray (wr_ptr_gray),
    .full        (full),
    .almost_full (almost_full),
    .wr_count    (wr_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"},   int'(mem_we), 0);
    chk({tag, "_addr"}, int'(wr_addr), 0);
    chk({tag, "_gray"}, int'(wr_ptr_gray), 0);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_af"},   int'(almost_full), 0);
    chk({tag, "_cnt"},  int'(wr_count), 0);
    chk({tag, "_ovf"},  int'(overflow), 0);
  endtask

  // Hand-computed tables
  int fill_gray [9] = '{1, 3, 2, 6, 7, 5, 4, 12, 12};
  int wrap_rd   [6] = '{6, 7, 5, 4, 12, 13};      // Gray of read bin 4..9
  int wrap_gray [6] = '{14, 10, 11, 9, 8, 0};     // Gray of write bin 11..16
  int cont_rd   [12] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10};
  int prev_g;

  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_ptr_sync = '0;
    #2;
    chk_zero("por");
    rst = 1'b1;
    tick();

    // Reset asserted mid-cycle while writing
    wr_en = 1'b1;
    tick(); tick();
    chk("pre_rst_gray", int'(wr_ptr_gray), 3);
    #3;
    rst = 1'b0;
    #1;
    chk_zero("mid_rst");
    tick();
    chk("rst_hold_gray", int'(wr_ptr_gray), 0);
    chk("rst_hold_we", int'(mem_we), 0);
    rst = 1'b1; wr_en = 1'b0;
    tick();
    chk("rel_idle_gray", int'(wr_ptr_gray), 0);

    // Fill: 9 write cycles against an empty read pointer
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1;
      #1;
      chk("fill_we", int'(mem_we), (i < 8) ? 1 : 0);
      chk("fill_addr", int'(wr_addr), (i < 8) ? i : 0);
      tick();
      chk("fill_gray", int'(wr_ptr_gray), fill_gray[i]);
      chk("fill_af", int'(almost_full), (i >= 5) ? 1 : 0);
      chk("fill_full", int'(full), (i >= 7) ? 1 : 0);
      chk("fill_cnt", int'(wr_count), (i < 8) ? i + 1 : 8);
      chk("fill_ovf", int'(overflow), (i == 8) ? 1 : 0);
    end

    // Overflow sticky, then a read frees two slots
    wr_en = 1'b0; tick();
    wr_en = 1'b1; tick();
    chk("ovf_full", int'(full), 1);
    chk("ovf_sticky", int'(overflow), 1);
    wr_en = 1'b0; rd_ptr_sync = 4'd3;
    tick();
    chk("rd_full", int'(full), 0);
    chk("rd_cnt", int'(wr_count), 6);
    chk("rd_af", int'(almost_full), 1);
    chk("rd_ovf", int'(overflow), 1);

    // Refill two slots
    wr_en = 1'b1;
    tick();
    chk("refill1_gray", int'(wr_ptr_gray), 13);
    chk("refill1_cnt", int'(wr_count), 7);
    chk("refill1_full", int'(full), 0);
    tick();
    chk("refill2_gray", int'(wr_ptr_gray), 15);
    chk("refill2_cnt", int'(wr_count), 8);
    chk("refill2_full", int'(full), 1);
    wr_en = 1'b0;

    // Wrap: free one slot, then push and read in step through the wrap
    rd_ptr_sync = 4'd2;
    tick();
    chk("wrap_pre_full", int'(full), 0);
    chk("wrap_pre_cnt", int'(wr_count), 7);
    prev_g = int'(wr_ptr_gray);
    for (int k = 0; k < 6; k++) begin
      wr_en = 1'b1;
      rd_ptr_sync = 4'(wrap_rd[k]);
      #1;
      chk("wrap_addr", int'(wr_addr), (10 + k) % 8);
      tick();
      chk("wrap_gray", int'(wr_ptr_gray), wrap_gray[k]);
      chk("wrap_1bit", $countones(4'(prev_g) ^ wr_ptr_gray), 1);
      chk("wrap_cnt", int'(wr_count), 7);
      chk("wrap_full", int'(full), 0);
      prev_g = int'(wr_ptr_gray);
    end
    #1;
    chk("wrap_addr_end", int'(wr_addr), 0);
    wr_en = 1'b0;

    // Continuous write and read from a fresh reset
    rst = 1'b0; rd_ptr_sync = '0;
    #1;
    chk("rst2_ovf", int'(overflow), 0);
    chk("rst2_gray", int'(wr_ptr_gray), 0);
    rst = 1'b1;
    wr_en = 1'b1;
    tick(); tick(); tick();
    chk("cont_pre_cnt", int'(wr_count), 3);
    for (int k = 0; k < 12; k++) begin
      rd_ptr_sync = 4'(cont_rd[k]);
      #1;
      chk("cont_we", int'(mem_we), 1);
      tick();
      chk("cont_cnt", int'(wr_count), 3);
      chk("cont_full", int'(full), 0);
      chk("cont_ovf", int'(overflow), 0);
    end
    wr_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
